// File: rtl/hazard_trap_ctrl_pkg.sv
// rtl/hazard_trap_ctrl_pkg.sv - shared pipeline-control state encoding, trap vectors and hazard helper
package hazard_trap_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_LDSTALL = 2'd1,
      ST_TRAP    = 2'd2
   } state_e;

   localparam logic [31:0] ILLOP_VEC_DEF = 32'h8000_0004;
   localparam logic [31:0] XADR_VEC_DEF  = 32'h8000_0008;

   // r0 is hardwired zero, so a load into it never creates a dependency.
   function automatic logic load_use_hazard(
      input logic       memread,
      input logic [4:0] ex_rt,
      input logic [4:0] id_rs,
      input logic [4:0] id_rt,
      input logic       uses_rt
   );
      return memread && (ex_rt != 5'd0) &&
             ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
   endfunction

endpackage

// File: rtl/hazard_trap_ctrl_irq_sync_edge.sv
// rtl/hazard_trap_ctrl_irq_sync_edge.sv - irq synchronizer, rising-edge detect and pending latch
module irq_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic irq,
   input  logic ack,
   output logic pending
);

   logic sync1_q, sync2_q, prev_q, pending_q;
   logic rise;
   logic pending_d;

   assign rise = sync2_q & ~prev_q;
   // A fresh edge on the ack cycle is a new request and must not be lost.
   assign pending_d = rise | (pending_q & ~ack);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         prev_q    <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         sync1_q   <= irq;
         sync2_q   <= sync1_q;
         prev_q    <= sync2_q;
         pending_q <= pending_d;
      end
   end

   assign pending = pending_q;

endmodule

// File: rtl/hazard_trap_ctrl.sv
// rtl/hazard_trap_ctrl.sv - hold/flush/trap sequencing for the IF/ID and ID/EX registers and PC
module hazard_trap_ctrl
   import hazard_trap_ctrl_pkg::*;
#(
   parameter logic [31:0] ILLOP_VEC = ILLOP_VEC_DEF,
   parameter logic [31:0] XADR_VEC  = XADR_VEC_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rt,
   input  logic        id_jump,
   input  logic [31:0] id_jump_target,
   input  logic        id_illop,
   input  logic [31:0] id_pc,
   input  logic        ex_memread,
   input  logic [4:0]  ex_rt,
   input  logic        ex_branch_taken,
   input  logic [31:0] ex_branch_target,
   input  logic        irq,
   input  logic        int_enable,
   output logic        pc_hold,
   output logic        ifid_hold,
   output logic        ifid_flush,
   output logic        idex_stall,
   output logic        idex_flush,
   output logic        idex_illop,
   output logic        idex_xadr,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic [31:0] epc,
   output logic        epc_we,
   output logic        irq_ack
);

   state_e      state_q, state_d;
   logic [31:0] epc_q;
   logic        irq_pending;
   logic        hazard;

   irq_sync_edge u_irq_sync_edge (
      .clk     (clk),
      .reset   (reset),
      .irq     (irq),
      .ack     (irq_ack),
      .pending (irq_pending)
   );

   assign hazard = load_use_hazard(ex_memread, ex_rt, id_rs, id_rt, id_uses_rt);

   always_comb begin
      state_d     = ST_RUN;
      pc_hold     = 1'b0;
      ifid_hold   = 1'b0;
      ifid_flush  = 1'b0;
      idex_stall  = 1'b0;
      idex_flush  = 1'b0;
      idex_illop  = 1'b0;
      idex_xadr   = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      epc_we      = 1'b0;
      irq_ack     = 1'b0;
      // Outputs are forced low while reset is held so the pipeline sees no strobes.
      if (!reset) begin
         case (state_q)
            ST_RUN, ST_LDSTALL: begin
               if (ex_branch_taken) begin
                  redirect    = 1'b1;
                  redirect_pc = ex_branch_target;
                  ifid_flush  = 1'b1;
                  idex_flush  = 1'b1;
               end else if (id_illop) begin
                  redirect    = 1'b1;
                  redirect_pc = ILLOP_VEC;
                  idex_illop  = 1'b1;
                  ifid_flush  = 1'b1;
                  epc_we      = 1'b1;
               end else if ((state_q == ST_RUN) && irq_pending && int_enable) begin
                  epc_we    = 1'b1;
                  irq_ack   = 1'b1;
                  pc_hold   = 1'b1;
                  ifid_hold = 1'b1;
                  idex_xadr = 1'b1;
                  state_d   = ST_TRAP;
               end else if (hazard) begin
                  pc_hold    = 1'b1;
                  ifid_hold  = 1'b1;
                  idex_stall = 1'b1;
                  state_d    = ST_LDSTALL;
               end else if (id_jump) begin
                  redirect    = 1'b1;
                  redirect_pc = id_jump_target;
                  ifid_flush  = 1'b1;
               end
            end
            ST_TRAP: begin
               redirect    = 1'b1;
               redirect_pc = XADR_VEC;
               ifid_flush  = 1'b1;
               idex_flush  = 1'b1;
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_RUN;
         epc_q   <= 32'h0;
      end else begin
         state_q <= state_d;
         if (epc_we) begin
            epc_q <= id_pc;
         end
      end
   end

   assign epc = epc_q;

endmodule

// File: tb/tb_hazard_trap_ctrl.sv
// tb/tb_hazard_trap_ctrl.sv - directed self-checking bench for hazard_trap_ctrl
module tb_hazard_trap_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  id_rs, id_rt, ex_rt;
   logic        id_uses_rt, id_jump, id_illop, ex_memread, ex_branch_taken, irq, int_enable;
   logic [31:0] id_jump_target, id_pc, ex_branch_target;
   logic        pc_hold, ifid_hold, ifid_flush, idex_stall, idex_flush, idex_illop, idex_xadr;
   logic        redirect, epc_we, irq_ack;
   logic [31:0] redirect_pc, epc;
   logic [9:0]  ctl;

   int n_tests = 0;
   int n_fail  = 0;

   // {pc_hold, ifid_hold, ifid_flush, idex_stall, idex_flush, idex_illop, idex_xadr, redirect, epc_we, irq_ack}
   localparam logic [9:0] C_NONE   = 10'b00_0000_0000;
   localparam logic [9:0] C_LDUSE  = 10'b11_0100_0000;
   localparam logic [9:0] C_JUMP   = 10'b00_1000_0100;
   localparam logic [9:0] C_BRANCH = 10'b00_1010_0100;
   localparam logic [9:0] C_ILLOP  = 10'b00_1001_0110;
   localparam logic [9:0] C_ACCEPT = 10'b11_0000_1011;
   localparam logic [9:0] C_TRAP   = 10'b00_1010_0100;

   assign ctl = {pc_hold, ifid_hold, ifid_flush, idex_stall, idex_flush,
                 idex_illop, idex_xadr, redirect, epc_we, irq_ack};

   always #5 clk = ~clk;

   hazard_trap_ctrl dut (
      .clk              (clk),
      .reset            (reset),
      .id_rs            (id_rs),
      .id_rt            (id_rt),
      .id_uses_rt       (id_uses_rt),
      .id_jump          (id_jump),
      .id_jump_target   (id_jump_target),
      .id_illop         (id_illop),
      .id_pc            (id_pc),
      .ex_memread       (ex_memread),
      .ex_rt            (ex_rt),
      .ex_branch_taken  (ex_branch_taken),
      .ex_branch_target (ex_branch_target),
      .irq              (irq),
      .int_enable       (int_enable),
      .pc_hold          (pc_hold),
      .ifid_hold        (ifid_hold),
      .ifid_flush       (ifid_flush),
      .idex_stall       (idex_stall),
      .idex_flush       (idex_flush),
      .idex_illop       (idex_illop),
      .idex_xadr        (idex_xadr),
      .redirect         (redirect),
      .redirect_pc      (redirect_pc),
      .epc              (epc),
      .epc_we           (epc_we),
      .irq_ack          (irq_ack)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
      id_uses_rt = 1'b0; id_jump = 1'b0; id_illop = 1'b0;
      ex_memread = 1'b0; ex_branch_taken = 1'b0;
      id_jump_target = 32'h0; id_pc = 32'h0; ex_branch_target = 32'h0;
   endtask

   initial begin
      quiet();
      irq = 1'b0;
      int_enable = 1'b0;
      reset = 1'b1;
      repeat (3) tick();
      check_eq("reset_ctl", {22'h0, ctl}, {22'h0, C_NONE});
      check_eq("reset_epc", epc, 32'h0);
      reset = 1'b0;
      tick();

      ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
      #1 check_eq("lduse_ctl", {22'h0, ctl}, {22'h0, C_LDUSE});
      tick();
      quiet();
      #1 check_eq("ldstall_ctl", {22'h0, ctl}, {22'h0, C_NONE});
      tick();
      #1 check_eq("lduse_back_run", {22'h0, ctl}, {22'h0, C_NONE});

      ex_memread = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1; id_rs = 5'd3;
      #1 check_eq("lduse_rt_ctl", {22'h0, ctl}, {22'h0, C_LDUSE});
      tick();
      quiet();

      ex_memread = 1'b1;
      #1 check_eq("zero_dest_ctl", {22'h0, ctl}, {22'h0, C_NONE});
      quiet();

      id_jump = 1'b1; id_jump_target = 32'h0000_0300;
      #1 check_eq("jump_ctl", {22'h0, ctl}, {22'h0, C_JUMP});
      check_eq("jump_pc", redirect_pc, 32'h0000_0300);
      tick();
      quiet();

      ex_branch_taken = 1'b1; ex_branch_target = 32'h0000_0040;
      id_illop = 1'b1; id_pc = 32'h0000_0abc;
      #1 check_eq("br_illop_ctl", {22'h0, ctl}, {22'h0, C_BRANCH});
      check_eq("br_illop_pc", redirect_pc, 32'h0000_0040);
      tick();
      check_eq("br_illop_epc", epc, 32'h0);
      quiet();

      id_illop = 1'b1; id_pc = 32'h0000_0100;
      #1 check_eq("illop_ctl", {22'h0, ctl}, {22'h0, C_ILLOP});
      check_eq("illop_pc", redirect_pc, 32'h8000_0004);
      tick();
      quiet();
      check_eq("illop_epc", epc, 32'h0000_0100);

      irq = 1'b1; int_enable = 1'b1; id_pc = 32'h0000_0200;
      tick();
      check_eq("irq_lat1", {31'h0, irq_ack}, 32'h0);
      tick();
      check_eq("irq_lat2", {31'h0, irq_ack}, 32'h0);
      tick();
      check_eq("irq_accept_ctl", {22'h0, ctl}, {22'h0, C_ACCEPT});
      tick();
      check_eq("irq_trap_ctl", {22'h0, ctl}, {22'h0, C_TRAP});
      check_eq("irq_trap_pc", redirect_pc, 32'h8000_0008);
      check_eq("irq_epc", epc, 32'h0000_0200);
      tick();
      check_eq("irq_cleared", {22'h0, ctl}, {22'h0, C_NONE});
      irq = 1'b0;
      repeat (4) tick();

      int_enable = 1'b0; irq = 1'b1; id_pc = 32'h0000_0500;
      for (int i = 0; i < 10; i++) begin
         tick();
         check_eq($sformatf("masked_%0d", i), {31'h0, irq_ack}, 32'h0);
      end
      int_enable = 1'b1; ex_branch_taken = 1'b1; ex_branch_target = 32'h0000_0080;
      #1 check_eq("irq_vs_branch_ctl", {22'h0, ctl}, {22'h0, C_BRANCH});
      tick();
      ex_branch_taken = 1'b0;
      #1 check_eq("unmask_accept_ctl", {22'h0, ctl}, {22'h0, C_ACCEPT});
      tick();
      check_eq("unmask_trap_ctl", {22'h0, ctl}, {22'h0, C_TRAP});
      check_eq("unmask_epc", epc, 32'h0000_0500);
      irq = 1'b0;
      reset = 1'b1;
      #1 check_eq("trap_reset_ctl", {22'h0, ctl}, {22'h0, C_NONE});
      check_eq("trap_reset_pc", redirect_pc, 32'h0);
      check_eq("trap_reset_epc", epc, 32'h0);
      tick();
      reset = 1'b0;
      tick();
      check_eq("post_reset_ctl", {22'h0, ctl}, {22'h0, C_NONE});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_trap_ctrl.md
# hazard_trap_ctrl

Pipeline control block that produces the hold, flush and trap signals consumed by the IF/ID and ID/EX pipeline registers and the PC unit. It detects load-use hazards and taken branches/jumps, and sequences illegal-opcode and external-interrupt traps into vector redirects with EPC capture. It is the source of the `flush`, `stall`, `illop` and `xadr` strobes that the ID/EX register clears on. It sits beside the ID stage and observes ID-stage decode fields and EX-stage control fields.

## Interface
Parameters:
- ILLOP_VEC, 32'h80000004, redirect target for an illegal opcode
- XADR_VEC, 32'h80000008, redirect target for an external interrupt

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- id_rs, id_rt  in  5  source registers of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
- id_jump  in  1  ID instruction is J/JAL/JR/JALR
- id_jump_target  in  32  jump target resolved in ID
- id_illop  in  1  ID opcode undecodable
- id_pc  in  32  PC of the instruction in ID
- ex_memread  in  1  EX instruction is a load
- ex_rt  in  5  load destination in EX
- ex_branch_taken  in  1  branch in EX resolved taken
- ex_branch_target  in  32  branch target
- irq  in  1  external interrupt request, asynchronous level
- int_enable  in  1  interrupts permitted (user mode)
- pc_hold  out  1  PC keeps its value
- ifid_hold  out  1  IF/ID keeps its contents
- ifid_flush  out  1  IF/ID loads a bubble
- idex_stall  out  1  ID/EX loads a bubble due to load-use
- idex_flush  out  1  ID/EX loads a bubble due to redirect
- idex_illop  out  1  illegal-opcode trap strobe to ID/EX
- idex_xadr  out  1  interrupt trap strobe to ID/EX
- redirect  out  1  PC loads redirect_pc
- redirect_pc  out  32  redirect target
- epc  out  32  captured exception PC (registered)
- epc_we  out  1  epc updated this cycle
- irq_ack  out  1  interrupt accepted

## Operation
- The irq input passes through a 2-flop synchronizer. A rising edge of the synchronized irq sets `irq_pending`. `irq_pending` clears only on `irq_ack`.
- Load-use hazard: `ex_memread && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt))`.
- States:
  - RUN: normal operation.
  - LDSTALL: one cycle after a load-use stall.
  - TRAP: one cycle, the redirect cycle of an interrupt.
- In RUN, evaluate in priority order; the first match wins:
  1. ex_branch_taken: `redirect=1`, `redirect_pc=ex_branch_target`, `ifid_flush=1`, `idex_flush=1`. Stay in RUN.
  2. id_illop: `redirect=1`, `redirect_pc=ILLOP_VEC`, `idex_illop=1`, `ifid_flush=1`, `epc_we=1`, `epc<=id_pc`. Stay in RUN.
  3. irq_pending && int_enable: `epc_we=1`, `epc<=id_pc`, `irq_ack=1`, `pc_hold=1`, `ifid_hold=1`, `idex_xadr=1`. Go to TRAP.
  4. Load-use hazard: `pc_hold=1`, `ifid_hold=1`, `idex_stall=1`. Go to LDSTALL.
  5. id_jump: `redirect=1`, `redirect_pc=id_jump_target`, `ifid_flush=1`. Stay in RUN.
- LDSTALL: EX now holds a bubble. Evaluate the RUN rules except rule 3, which is deferred one cycle. Return to RUN unless rule 4 fires again.
- TRAP: `redirect=1`, `redirect_pc=XADR_VEC`, `ifid_flush=1`, `idex_flush=1`. Go to RUN unconditionally.
- All outputs except `epc` are combinational from state and inputs. They are sampled by the pipeline registers at the next edge.
- Reset values: every output 0, `epc=0`, state RUN, synchronizer and `irq_pending` cleared.

## Timing
- Load-use costs exactly 1 bubble. Taken branch costs 2 bubbles. Jump costs 1 bubble. Interrupt costs 2 cycles (accept, then redirect).
- `epc` is valid the cycle after `epc_we`.
- irq-to-accept latency is at least 3 cycles: 2 synchronizer cycles plus 1 edge-detect cycle.
- A branch that is simultaneously taken wins over illop/irq/jump in the same cycle. The irq stays pending.
- When `irq_pending` and `int_enable=0`, the request is held indefinitely and accepted on the first eligible cycle.
- An irq edge arriving while `irq_pending=1` is merged into the single pending request.
- Reset asserted in TRAP or LDSTALL returns the block to RUN immediately and drops any pending irq.

## Structure
- The shared CPU package holds the state encoding (RUN, LDSTALL, TRAP) and the ILLOP_VEC/XADR_VEC defaults.
- One sub-module: `irq_sync_edge`, containing the 2-flop synchronizer, rising-edge detect and pending latch with ack clear.

## Test plan
- Load-use hazard: `ex_memread=1`, `ex_rt=5`, `id_rs=5` → `pc_hold`, `ifid_hold` and `idex_stall` high for 1 cycle, state LDSTALL, then back to RUN with outputs low.
- Load with zero destination: `ex_rt=0`, `id_rs=0` → no stall.
- Branch plus illop: `ex_branch_taken=1` and `id_illop=1` in the same cycle, target 32'h00000040 → `redirect_pc=32'h00000040`, `idex_illop=0`, `epc_we=0`.
- Illegal opcode: `id_illop=1`, `id_pc=32'h00000100` → `redirect_pc=32'h80000004`, `idex_illop=1`, `epc=32'h00000100` on the next cycle.
- Interrupt: irq rises, `int_enable=1`, `id_pc=32'h00000200` → `irq_ack` and `idex_xadr` after 3 cycles; next cycle `redirect_pc=32'h80000008`; `epc=32'h00000200`; `irq_pending` cleared.
- Masked interrupt and mid-TRAP reset: irq with `int_enable=0` for 10 cycles → no ack; `int_enable` raised → ack on that cycle. Separately, reset asserted in TRAP → all outputs 0 asynchronously.
